regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised dual-write-port register file with write-through read bypass, a per-register pending scoreboard for multicycle units, and a configurable bank of tap outputs. Sits in the processor decode/writeback stage. Port W0 carries the main pipeline writeback. Port W1 carries late results from the multiply/divide unit. Pending flags let the hazard unit stall readers of registers whose result is still in flight.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH
TAP_BASE, 26, index of first register exported on reg_tap
TAP_COUNT, 4, number of consecutive registers exported; TAP_BASE+TAP_COUNT <= DEPTH, TAP_BASE >= 1

Ports:
clock  in  1  single clock, rising edge
ctrl_reset  in  1  synchronous reset, active-low (0 = reset)
ctrl_writeEnable  in  1  W0 write enable
ctrl_writeReg  in  ADDR_WIDTH  W0 destination
data_writeReg  in  DATA_WIDTH  W0 data
ctrl_writeEnable2  in  1  W1 (multdiv) write enable
ctrl_writeReg2  in  ADDR_WIDTH  W1 destination
data_writeReg2  in  DATA_WIDTH  W1 data
ctrl_claim  in  1  mark ctrl_claimReg pending (multicycle op issued)
ctrl_claimReg  in  ADDR_WIDTH  register to claim
ctrl_readRegA  in  ADDR_WIDTH  read port A address
ctrl_readRegB  in  ADDR_WIDTH  read port B address
data_readRegA  out  DATA_WIDTH  read port A data (combinational)
data_readRegB  out  DATA_WIDTH  read port B data (combinational)
pending_readA  out  1  port A register awaiting W1 result (combinational)
pending_readB  out  1  port B register awaiting W1 result (combinational)
claim_conflict  out  1  registered one-cycle pulse: claim hit an already-pending register
reg_tap  out  TAP_COUNT*DATA_WIDTH  raw stored contents of taps; slice k = register TAP_BASE+k

Behaviour:
- Reset: on a rising edge with ctrl_reset=0, all registers, all pending bits and claim_conflict go to 0. All writes and claims in that cycle are ignored. Reset asserted mid-operation discards in-flight pending state. Reads during reset return stored values plus bypass, which are 0 from the following cycle.
- Register 0: reads always 0. Writes from either port are ignored. Claims are ignored. Register 0 is never pending and is never bypassed.
- Writes: take effect at the rising edge. Both ports to the same nonzero register in one cycle: W0 data is stored (younger pipeline instruction wins).
- Pending scoreboard: one bit per register.
  - Set by ctrl_claim at the edge.
  - Cleared by a W1 write to that register at the edge.
  - A W0 write does not clear it.
  - Claim and W1 write to the same register in one cycle: bit ends 1 (new claim wins).
- claim_conflict: goes to 1 on the cycle after a claim to a nonzero register whose bit was already 1 and is not being cleared by W1 that cycle. Otherwise 0.
- Read path, zero latency. Address 0 returns 0. Otherwise priority is W0 data if W0 writes that address this cycle, else W1 data if W1 writes it, else stored value.
- pending_readX = pending[addr] & ~(ctrl_writeEnable2 & ctrl_writeReg2==addr) & (addr!=0).
- reg_tap: stored values only, no bypass. Updates one cycle after the write.
- No arithmetic. All widths set by parameters, no truncation. Out-of-range tap parameters are a static configuration error and need not be handled.

Test Plan:
- Reset/zero: hold ctrl_reset=0 one edge, then W0 writes 0xDEADBEEF to r0 and 0x12345678 to r5 -> readA(r0)=0; readB(r5)=0x12345678 after the edge; all reg_tap slices 0 before the write.
- Bypass: W0 writes 0xA5A5A5A5 to r7 while readA=r7 -> data_readRegA=0xA5A5A5A5 in the same cycle. Same cycle, W0 and W1 both target r9 with 0x1 and 0x2 -> readB(r9)=0x1 combinationally and 0x1 stored.
- Scoreboard: claim r12 -> pending_readA(r12)=1 next cycle. W1 writes 0x77 to r12 -> pending_readA=0 that same cycle, readA=0x77. After the edge the pending bit stays 0.
- Claim/clear collision: r12 pending, then in one cycle claim r12 and W1 writes r12 -> pending bit 1 afterwards, claim_conflict=0. A second claim of r12 -> claim_conflict=1 for exactly one cycle.
- Taps (defaults): W0 writes 0x11,0x22,0x33,0x44 to r26..r29 on consecutive cycles -> reg_tap[127:0]=0x00000044_00000033_00000022_00000011 after the last edge; each slice lags its write by one cycle.
- Reset mid-operation: claim r3, write r3=0x5, assert ctrl_reset=0 for one edge -> pending_readA(r3)=0 and readA(r3)=0 afterwards.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: both write ports, the claim port, the read ports and the tap bank.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAP_COUNT  = 4
);
  logic                            ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]           ctrl_writeReg;
  logic [DATA_WIDTH-1:0]           data_writeReg;
  logic                            ctrl_writeEnable2;
  logic [ADDR_WIDTH-1:0]           ctrl_writeReg2;
  logic [DATA_WIDTH-1:0]           data_writeReg2;
  logic                            ctrl_claim;
  logic [ADDR_WIDTH-1:0]           ctrl_claimReg;
  logic [ADDR_WIDTH-1:0]           ctrl_readRegA;
  logic [ADDR_WIDTH-1:0]           ctrl_readRegB;
  logic [DATA_WIDTH-1:0]           data_readRegA;
  logic [DATA_WIDTH-1:0]           data_readRegB;
  logic                            pending_readA;
  logic                            pending_readB;
  logic                            claim_conflict;
  logic [TAP_COUNT*DATA_WIDTH-1:0] reg_tap;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_writeEnable2, ctrl_writeReg2, data_writeReg2,
    output ctrl_claim, ctrl_claimReg, ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB, pending_readA, pending_readB,
    input  claim_conflict, reg_tap
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_writeEnable2, ctrl_writeReg2, data_writeReg2,
    input  ctrl_claim, ctrl_claimReg, ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB, pending_readA, pending_readB,
    output claim_conflict, reg_tap
  );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write register file with write-through bypass, a pending scoreboard for
// multicycle results arriving on W1, and a bank of raw register taps.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TAP_BASE   = 26,
  parameter int TAP_COUNT  = 4
) (
  input logic         clock,
  input logic         ctrl_reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;
  logic [DEPTH-1:0]      pending_nxt;
  logic                  conflict_q;
  logic                  conflict_nxt;
  logic                  w0_ok;
  logic                  w1_ok;

  // W0 beats W1 on a shared address; register 0 is never bypassed.
  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we0,
    input logic [ADDR_WIDTH-1:0] wa0,
    input logic [DATA_WIDTH-1:0] wd0,
    input logic                  we1,
    input logic [ADDR_WIDTH-1:0] wa1,
    input logic [DATA_WIDTH-1:0] wd1
  );
    if (addr == '0)                  return '0;
    else if (we0 && (wa0 == addr))   return wd0;
    else if (we1 && (wa1 == addr))   return wd1;
    else                             return stored;
  endfunction

  assign w0_ok = bus.ctrl_writeEnable  && (bus.ctrl_writeReg  != '0);
  assign w1_ok = bus.ctrl_writeEnable2 && (bus.ctrl_writeReg2 != '0);

  // Clear from W1 first so a same-cycle claim leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (w1_ok) pending_nxt[bus.ctrl_writeReg2] = 1'b0;
    if (bus.ctrl_claim) pending_nxt[bus.ctrl_claimReg] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign conflict_nxt = bus.ctrl_claim && (bus.ctrl_claimReg != '0) &&
                        pending[bus.ctrl_claimReg] &&
                        !(bus.ctrl_writeEnable2 && (bus.ctrl_writeReg2 == bus.ctrl_claimReg));

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending    <= '0;
      conflict_q <= 1'b0;
    end else begin
      if (w1_ok) regs[bus.ctrl_writeReg2] <= bus.data_writeReg2;
      if (w0_ok) regs[bus.ctrl_writeReg]  <= bus.data_writeReg;
      pending    <= pending_nxt;
      conflict_q <= conflict_nxt;
    end
  end

  always_comb begin
    bus.data_readRegA = read_sel(bus.ctrl_readRegA, regs[bus.ctrl_readRegA],
                                 bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg,
                                 bus.ctrl_writeEnable2, bus.ctrl_writeReg2, bus.data_writeReg2);
    bus.data_readRegB = read_sel(bus.ctrl_readRegB, regs[bus.ctrl_readRegB],
                                 bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg,
                                 bus.ctrl_writeEnable2, bus.ctrl_writeReg2, bus.data_writeReg2);
  end

  assign bus.pending_readA = pending[bus.ctrl_readRegA] &&
                             !(bus.ctrl_writeEnable2 && (bus.ctrl_writeReg2 == bus.ctrl_readRegA)) &&
                             (bus.ctrl_readRegA != '0);
  assign bus.pending_readB = pending[bus.ctrl_readRegB] &&
                             !(bus.ctrl_writeEnable2 && (bus.ctrl_writeReg2 == bus.ctrl_readRegB)) &&
                             (bus.ctrl_readRegB != '0);

  assign bus.claim_conflict = conflict_q;

  for (genvar k = 0; k < TAP_COUNT; k++) begin : g_tap
    assign bus.reg_tap[k*DATA_WIDTH +: DATA_WIDTH] = regs[TAP_BASE+k];
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios with literal expectations, then random
// traffic checked every cycle against an array-based model of the register file.
module tb_regfile_sb;
  logic clock;
  logic rst_n;

  regfile_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TAP_COUNT(4)) bus ();

  regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TAP_BASE(26), .TAP_COUNT(4)) dut (
    .clock(clock), .ctrl_reset(rst_n), .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: plain arrays updated from the rules at every rising edge.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_conf;
  bit          m_valid = 0;

  always @(posedge clock) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_pend[i] = 1'b0;
      end
      m_conf  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      int c, w0, w1;
      c  = bus.ctrl_claimReg;
      w0 = bus.ctrl_writeReg;
      w1 = bus.ctrl_writeReg2;
      m_conf = bus.ctrl_claim && c != 0 && m_pend[c] && !(bus.ctrl_writeEnable2 && w1 == c);
      if (bus.ctrl_writeEnable && w0 != 0)       m_regs[w0] = bus.data_writeReg;
      else if (bus.ctrl_writeEnable2 && w1 != 0) m_regs[w1] = bus.data_writeReg2;
      if (bus.ctrl_writeEnable2 && w1 != 0 && bus.ctrl_writeEnable && w0 != w1)
        m_regs[w1] = bus.data_writeReg2;
      if (bus.ctrl_writeEnable2) m_pend[w1] = 1'b0;
      if (bus.ctrl_claim && c != 0) m_pend[c] = 1'b1;
    end
  end

  function automatic logic [31:0] exp_rd(input int a);
    if (a == 0) return 32'h0;
    if (bus.ctrl_writeEnable && bus.ctrl_writeReg == 5'(a)) return bus.data_writeReg;
    if (bus.ctrl_writeEnable2 && bus.ctrl_writeReg2 == 5'(a)) return bus.data_writeReg2;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input int a);
    if (a == 0) return 1'b0;
    return m_pend[a] && !(bus.ctrl_writeEnable2 && bus.ctrl_writeReg2 == 5'(a));
  endfunction

  always @(negedge clock) begin
    if (m_valid) begin
      logic [127:0] taps;
      int ra, rb;
      ra = bus.ctrl_readRegA;
      rb = bus.ctrl_readRegB;
      taps = {m_regs[29], m_regs[28], m_regs[27], m_regs[26]};
      chk("readA", 128'(bus.data_readRegA), 128'(exp_rd(ra)));
      chk("readB", 128'(bus.data_readRegB), 128'(exp_rd(rb)));
      chk("pendA", 128'(bus.pending_readA), 128'(exp_pend(ra)));
      chk("pendB", 128'(bus.pending_readB), 128'(exp_pend(rb)));
      chk("conflict", 128'(bus.claim_conflict), 128'(m_conf));
      chk("taps", bus.reg_tap, taps);
    end
  end

  task automatic idle();
    bus.ctrl_writeEnable  = 0; bus.ctrl_writeReg  = 0; bus.data_writeReg  = 0;
    bus.ctrl_writeEnable2 = 0; bus.ctrl_writeReg2 = 0; bus.data_writeReg2 = 0;
    bus.ctrl_claim = 0; bus.ctrl_claimReg = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic w0(input int a, input logic [31:0] d);
    bus.ctrl_writeEnable = 1; bus.ctrl_writeReg = 5'(a); bus.data_writeReg = d;
  endtask

  task automatic w1(input int a, input logic [31:0] d);
    bus.ctrl_writeEnable2 = 1; bus.ctrl_writeReg2 = 5'(a); bus.data_writeReg2 = d;
  endtask

  task automatic claim(input int a);
    bus.ctrl_claim = 1; bus.ctrl_claimReg = 5'(a);
  endtask

  function automatic int rand_addr();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 31));
      1:       return int'($urandom_range(0, 3));
      2:       return int'($urandom_range(26, 29));
      default: return int'($urandom_range(8, 11));
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    bus.ctrl_readRegA = 0; bus.ctrl_readRegB = 0;
    #1;
    tick();
    rst_n = 1'b1;
    chk("tap_reset", bus.reg_tap, 128'h0);

    // Register 0 ignores writes; r5 stores.
    w0(0, 32'hDEADBEEF); tick();
    idle(); w0(5, 32'h12345678); tick();
    idle(); bus.ctrl_readRegA = 0; bus.ctrl_readRegB = 5; #1;
    chk("r0_zero", 128'(bus.data_readRegA), 128'h0);
    chk("r5_stored", 128'(bus.data_readRegB), 128'h12345678);

    // Bypass paths.
    w0(7, 32'hA5A5A5A5); bus.ctrl_readRegA = 7; #1;
    chk("bypass_w0", 128'(bus.data_readRegA), 128'hA5A5A5A5);
    idle(); w0(9, 32'h1); w1(9, 32'h2); bus.ctrl_readRegB = 9; #1;
    chk("bypass_both", 128'(bus.data_readRegB), 128'h1);
    tick(); idle(); #1;
    chk("both_stored", 128'(bus.data_readRegB), 128'h1);

    // Scoreboard set and clear.
    claim(12); tick(); idle(); bus.ctrl_readRegA = 12; #1;
    chk("pend_set", 128'(bus.pending_readA), 128'h1);
    w1(12, 32'h77); #1;
    chk("pend_w1_same", 128'(bus.pending_readA), 128'h0);
    chk("w1_bypass", 128'(bus.data_readRegA), 128'h77);
    tick(); idle(); #1;
    chk("pend_cleared", 128'(bus.pending_readA), 128'h0);

    // Claim/clear collision then a real conflict.
    claim(12); tick(); idle();
    claim(12); w1(12, 32'h88); tick(); idle(); #1;
    chk("pend_claim_wins", 128'(bus.pending_readA), 128'h1);
    chk("no_conflict", 128'(bus.claim_conflict), 128'h0);
    claim(12); tick(); idle(); #1;
    chk("conflict_pulse", 128'(bus.claim_conflict), 128'h1);
    tick();
    chk("conflict_drop", 128'(bus.claim_conflict), 128'h0);

    // Taps lag their writes by one edge.
    w0(26, 32'h11); tick();
    idle(); w0(27, 32'h22); tick();
    idle(); w0(28, 32'h33); tick();
    idle(); w0(29, 32'h44); #1;
    chk("tap_lag", 128'(bus.reg_tap[127:96]), 128'h0);
    tick(); idle(); #1;
    chk("taps_all", bus.reg_tap, 128'h00000044_00000033_00000022_00000011);

    // Mid-operation reset discards pending and data.
    claim(3); tick(); idle();
    w0(3, 32'h5); tick(); idle();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.ctrl_readRegA = 3; #1;
    chk("rst_pend", 128'(bus.pending_readA), 128'h0);
    chk("rst_data", 128'(bus.data_readRegA), 128'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      rst_n                 = ($urandom_range(0, 99) != 0);
      bus.ctrl_writeEnable  = ($urandom_range(0, 1) == 1);
      bus.ctrl_writeReg     = 5'(rand_addr());
      bus.data_writeReg     = $urandom;
      bus.ctrl_writeEnable2 = ($urandom_range(0, 2) == 0);
      bus.ctrl_writeReg2    = 5'(rand_addr());
      bus.data_writeReg2    = $urandom;
      bus.ctrl_claim        = ($urandom_range(0, 2) == 0);
      bus.ctrl_claimReg     = 5'(rand_addr());
      bus.ctrl_readRegA     = 5'(rand_addr());
      bus.ctrl_readRegB     = 5'(rand_addr());
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
